// File: rtl/sr_pulse_gen_pkg.sv
// sr_pulse_gen_pkg
//   Shared definitions for the SR pulse generator: FSM state encodings and
//   the debounce/pulse counter width.
//   No ports.
package sr_pulse_gen_pkg;

    // Counter is cleared on every state entry, so 8 bits covers the full
    // 1..255 range of both parameters without wrapping.
    localparam int SR_CNT_W = 8;

    typedef enum logic [2:0] {
        ST_LOW       = 3'd0,
        ST_RISE_CHK  = 3'd1,
        ST_SET_PULSE = 3'd2,
        ST_HIGH      = 3'd3,
        ST_FALL_CHK  = 3'd4,
        ST_RST_PULSE = 3'd5
    } sr_state_e;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff
//   Two-flop synchroniser for a single asynchronous level. Reusable.
//   clk   : sampling clock, rising edge
//   rst_n : asynchronous active-low reset, both flops clear to 0
//   d     : asynchronous input
//   q     : synchronised output, two clk edges after d
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/sr_pulse_gen.sv
// sr_pulse_gen
//   Synchronises and debounces a noisy level, then emits a one-shot set
//   pulse on each confirmed rise and a one-shot reset pulse on each
//   confirmed fall, feeding a downstream SR latch.
//   DEBOUNCE_CYCLES : consecutive samples at the new value to commit (1..255)
//   PULSE_WIDTH     : cycles s/r stay high per commit (1..255)
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   din    : asynchronous, possibly bouncing level
//   s      : set pulse (registered)
//   r      : reset pulse (registered)
//   level  : committed debounced level (registered)
//   glitch : one-cycle pulse when a candidate transition is rejected
module sr_pulse_gen
    import sr_pulse_gen_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned PULSE_WIDTH     = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic s,
    output logic r,
    output logic level,
    output logic glitch
);

    localparam int CW1 = SR_CNT_W + 1;
    localparam logic [CW1-1:0] DEB_N = CW1'(DEBOUNCE_CYCLES);
    localparam logic [CW1-1:0] PW_N  = CW1'(PULSE_WIDTH);

    logic                din_sync;
    sr_state_e           state, state_nxt;
    logic [SR_CNT_W-1:0] cnt, cnt_nxt;
    logic [CW1-1:0]      cnt_w;
    logic                level_nxt, glitch_nxt;

    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (din),
        .q     (din_sync)
    );

    assign cnt_w = {1'b0, cnt};

    // The sample that moves LOW/HIGH into a check state is the first of the
    // DEBOUNCE_CYCLES samples, so the check state commits once it has seen
    // DEBOUNCE_CYCLES-1 more (cnt + 2 == DEBOUNCE_CYCLES). A debounce of 1
    // therefore commits straight from LOW/HIGH.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        level_nxt  = level;
        glitch_nxt = 1'b0;
        case (state)
            ST_LOW: begin
                if (din_sync) begin
                    cnt_nxt = '0;
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_nxt = ST_SET_PULSE;
                        level_nxt = 1'b1;
                    end else begin
                        state_nxt = ST_RISE_CHK;
                    end
                end
            end
            ST_RISE_CHK: begin
                if (!din_sync) begin
                    state_nxt  = ST_LOW;
                    glitch_nxt = 1'b1;
                    cnt_nxt    = '0;
                end else if (cnt_w + CW1'(2) == DEB_N) begin
                    state_nxt = ST_SET_PULSE;
                    level_nxt = 1'b1;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ST_SET_PULSE: begin
                // din_sync deliberately not looked at while pulsing
                if (cnt_w + CW1'(1) == PW_N) begin
                    state_nxt = ST_HIGH;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ST_HIGH: begin
                if (!din_sync) begin
                    cnt_nxt = '0;
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_nxt = ST_RST_PULSE;
                        level_nxt = 1'b0;
                    end else begin
                        state_nxt = ST_FALL_CHK;
                    end
                end
            end
            ST_FALL_CHK: begin
                if (din_sync) begin
                    state_nxt  = ST_HIGH;
                    glitch_nxt = 1'b1;
                    cnt_nxt    = '0;
                end else if (cnt_w + CW1'(2) == DEB_N) begin
                    state_nxt = ST_RST_PULSE;
                    level_nxt = 1'b0;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ST_RST_PULSE: begin
                if (cnt_w + CW1'(1) == PW_N) begin
                    state_nxt = ST_LOW;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                // unused encodings 6/7
                state_nxt = ST_LOW;
                cnt_nxt   = '0;
            end
        endcase
    end

    // s/r decode the next state so they are registered alongside level;
    // the two pulse states are exclusive, so s & r can never both be set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_LOW;
            cnt    <= '0;
            level  <= 1'b0;
            glitch <= 1'b0;
            s      <= 1'b0;
            r      <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            level  <= level_nxt;
            glitch <= glitch_nxt;
            s      <= (state_nxt == ST_SET_PULSE);
            r      <= (state_nxt == ST_RST_PULSE);
        end
    end

endmodule

// File: tb/tb_sr_pulse_gen.sv
// tb_sr_pulse_gen
//   Three instances share clk/rst_n/din: defaults (4,1), wide pulse (4,3)
//   and single-sample debounce (1,1). Each is compared every cycle against
//   a run-length reference model, plus a directed vector table and
//   hand-written reset/latency sequences.
module tb_sr_pulse_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       din;
    logic [2:0] so, ro, lo, go;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sr_pulse_gen #(.DEBOUNCE_CYCLES(4), .PULSE_WIDTH(1)) u_def (
        .clk(clk), .rst_n(rst_n), .din(din),
        .s(so[0]), .r(ro[0]), .level(lo[0]), .glitch(go[0]));

    sr_pulse_gen #(.DEBOUNCE_CYCLES(4), .PULSE_WIDTH(3)) u_pw3 (
        .clk(clk), .rst_n(rst_n), .din(din),
        .s(so[1]), .r(ro[1]), .level(lo[1]), .glitch(go[1]));

    sr_pulse_gen #(.DEBOUNCE_CYCLES(1), .PULSE_WIDTH(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .din(din),
        .s(so[2]), .r(ro[2]), .level(lo[2]), .glitch(go[2]));

    // ---------------- reference model ----------------
    // level commits after D consecutive synchronised samples differing from
    // it; then a pulse of PW cycles during which input is ignored.
    int P_D[3] = '{4, 4, 1};
    int P_W[3] = '{1, 3, 1};
    int m_lvl[3], m_run[3], m_left[3], m_g[3];
    logic sq1, sq2;

    task automatic model_reset();
        sq1 = 1'b0;
        sq2 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            m_lvl[k] = 0; m_run[k] = 0; m_left[k] = 0; m_g[k] = 0;
        end
    endtask

    task automatic model_step(input logic d);
        int ds;
        ds  = int'(sq2);
        sq2 = sq1;
        sq1 = d;
        for (int k = 0; k < 3; k++) begin
            m_g[k] = 0;
            if (m_left[k] > 0) begin
                m_left[k]--;
                m_run[k] = 0;
            end else if (ds != m_lvl[k]) begin
                m_run[k]++;
                if (m_run[k] == P_D[k]) begin
                    m_lvl[k]  = ds;
                    m_left[k] = P_W[k];
                    m_run[k]  = 0;
                end
            end else if (m_run[k] > 0) begin
                m_g[k]   = 1;
                m_run[k] = 0;
            end
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("s[%0d]", k), int'(so[k]),
                int'(m_left[k] > 0 && m_lvl[k] == 1));
            chk($sformatf("r[%0d]", k), int'(ro[k]),
                int'(m_left[k] > 0 && m_lvl[k] == 0));
            chk($sformatf("level[%0d]", k), int'(lo[k]), m_lvl[k]);
            chk($sformatf("glitch[%0d]", k), int'(go[k]), m_g[k]);
            chk($sformatf("s&r[%0d]", k), int'(so[k] & ro[k]), 0);
            chk($sformatf("s_wo_lvl[%0d]", k), int'(so[k] & ~lo[k]), 0);
            chk($sformatf("r_w_lvl[%0d]", k), int'(ro[k] & lo[k]), 0);
        end
    endtask

    // Drive din before an edge, advance the model, check just after the edge.
    task automatic cycle(input logic d);
        din = d;
        @(posedge clk);
        if (rst_n) model_step(d);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        cycle(1'b0);
        cycle(1'b0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic din;
        logic s, r, lvl, g;
        logic s3, r3;
    } vec_t;

    vec_t tbl[25];

    initial begin
        logic [0:24] c_din, c_s, c_r, c_lvl, c_g, c_s3, c_r3;
        logic        d;
        int          lat, s_cnt, r_cnt, s_at, r_at;

        // edge index:  0123456789012345678901234
        c_din = 25'b1111111001111110000000000;
        c_s   = 25'b0000010000000000000000000;
        c_r   = 25'b0000000000000000000010000;
        c_lvl = 25'b0000011111111111111100000;
        c_g   = 25'b0000000000010000000000000;
        c_s3  = 25'b0000011100000000000000000;
        c_r3  = 25'b0000000000000000000011100;
        for (int i = 0; i < 25; i++)
            tbl[i] = '{c_din[i], c_s[i], c_r[i], c_lvl[i], c_g[i], c_s3[i], c_r3[i]};

        // reset state
        din   = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_s", int'(so), 0);
        chk("rst_r", int'(ro), 0);
        chk("rst_level", int'(lo), 0);
        chk("rst_glitch", int'(go), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // rise, fall glitch from HIGH, clean fall
        for (int i = 0; i < 25; i++) begin
            cycle(tbl[i].din);
            chk($sformatf("tbl%0d_s", i),     int'(so[0]), int'(tbl[i].s));
            chk($sformatf("tbl%0d_r", i),     int'(ro[0]), int'(tbl[i].r));
            chk($sformatf("tbl%0d_level", i), int'(lo[0]), int'(tbl[i].lvl));
            chk($sformatf("tbl%0d_glitch", i), int'(go[0]), int'(tbl[i].g));
            chk($sformatf("tbl%0d_s3", i),    int'(so[1]), int'(tbl[i].s3));
            chk($sformatf("tbl%0d_r3", i),    int'(ro[1]), int'(tbl[i].r3));
            chk($sformatf("tbl%0d_level3", i), int'(lo[1]), int'(tbl[i].lvl));
        end

        // fast toggling: model + invariants checked every cycle
        d = 1'b0;
        for (int i = 0; i < 20; i++) begin
            d = ~d;
            cycle(d);
        end
        do_reset();

        // reset asserted mid s pulse, then latency from release
        for (int i = 0; i < 20 && !so[0]; i++) cycle(1'b1);
        chk("mid_s_seen", int'(so[0]), 1);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_s", int'(so[0]), 0);
        chk("async_level", int'(lo[0]), 0);
        chk("async_glitch", int'(go[0]), 0);
        chk("async_r", int'(ro[0]), 0);
        cycle(1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        lat = 0;
        for (int n = 1; n <= 12; n++) begin
            cycle(1'b1);
            if (so[0] && lat == 0) lat = n;
        end
        chk("release_latency", lat, 6);
        do_reset();

        // single-sample debounce: high 10, low 10
        s_cnt = 0; r_cnt = 0; s_at = -1; r_at = -1;
        for (int n = 0; n < 24; n++) begin
            cycle(n < 10 ? 1'b1 : 1'b0);
            if (so[2]) begin s_cnt++; if (s_at < 0) s_at = n; end
            if (ro[2]) begin r_cnt++; if (r_at < 0) r_at = n; end
        end
        chk("d1_s_width", s_cnt, 1);
        chk("d1_r_width", r_cnt, 1);
        chk("d1_s_at", s_at, 2);
        chk("d1_spacing", r_at - s_at, 10);

        // randomized run-length stimulus
        d = 1'b0;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 3) == 0) d = ~d;
            cycle(d);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
